mem_byte_ctrl: RTL and testbench

Multicycle memory-access sequencer between the 16-bit datapath control FSM and a byte-wide synchronous data memory. It accepts one load/store request at a time and issues one or two byte accesses. It assembles 16-bit load results: a byte load is zero-extended, and a word load is little-endian from two bytes. It reports completion with a one-cycle `done` pulse.

---
 rtl/mem_byte_ctrl.sv | 155 +++++++++++++++
 tb/tb_mem_byte_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_ctrl.sv
//============================================================================
// Module  : mem_byte_ctrl
// Brief   : Sequences 16-bit load/store requests onto a byte-wide
//           synchronous memory, one or two byte accesses per request.
// Revision: 1.0
//============================================================================
`default_nettype none

module mem_byte_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       rdata,
    output logic              misalign,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_LO  = 3'd1,
        RD_HI  = 3'd2,
        CAP_LO = 3'd3,
        CAP_HI = 3'd4,
        WR_LO  = 3'd5,
        WR_HI  = 3'd6,
        FIN    = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic [7:0]        r_lo;
    logic [15:0]       r_rdata;
    logic              r_mis;
    logic [ADDR_W-1:0] w_addr_hi;

    // op[0] selects word width, op[1] selects store
    wire w_start_mis = op[0] & addr[0];

    assign w_addr_hi = {r_addr[ADDR_W-1:1], 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_start_mis)
                        w_next = FIN;
                    else if (op[1])
                        w_next = WR_LO;
                    else
                        w_next = RD_LO;
                end
            end
            RD_LO:   w_next = r_op[0] ? RD_HI : CAP_LO;
            RD_HI:   w_next = CAP_HI;
            CAP_LO:  w_next = FIN;
            CAP_HI:  w_next = FIN;
            WR_LO:   w_next = r_op[0] ? WR_HI : FIN;
            WR_HI:   w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= 2'b00;
            r_addr  <= '0;
            r_wdata <= 16'h0000;
            r_lo    <= 8'h00;
            r_rdata <= 16'h0000;
            r_mis   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_mis   <= w_start_mis;
                    end
                end
                // First read byte arrives while the high byte is being addressed
                RD_HI:  r_lo    <= mem_rdata;
                CAP_LO: r_rdata <= {8'h00, mem_rdata};
                CAP_HI: r_rdata <= {mem_rdata, r_lo};
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (r_state != IDLE);
        done      = 1'b0;
        misalign  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        case (r_state)
            RD_LO: begin
                mem_en   = 1'b1;
                mem_addr = r_addr;
            end
            RD_HI: begin
                mem_en   = 1'b1;
                mem_addr = w_addr_hi;
            end
            WR_LO: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr;
                mem_wdata = r_wdata[7:0];
            end
            WR_HI: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_addr_hi;
                mem_wdata = r_wdata[15:8];
            end
            FIN: begin
                done     = 1'b1;
                misalign = r_mis;
            end
            default: ;
        endcase
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_byte_ctrl.sv
//============================================================================
// Module  : tb_mem_byte_ctrl
// Brief   : Scoreboard bench for mem_byte_ctrl with a byte memory model.
// Revision: 1.0
//============================================================================
`default_nettype none

module tb_mem_byte_ctrl;

    localparam logic [1:0] OP_LB = 2'b00;
    localparam logic [1:0] OP_LW = 2'b01;
    localparam logic [1:0] OP_SB = 2'b10;
    localparam logic [1:0] OP_SW = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic        busy, done, misalign, mem_en, mem_we;
    logic [15:0] rdata, mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    logic [7:0]  mem [0:255];

    typedef struct {
        int          cyc;
        logic [15:0] rd;
        logic        mis;
    } done_t;

    typedef struct {
        logic        we;
        logic [15:0] a;
        logic [7:0]  d;
    } acc_t;

    done_t       done_q[$];
    acc_t        acc_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] model_rd = 16'h0000;

    mem_byte_ctrl #(.ADDR_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .misalign  (misalign),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous byte memory: read data appears the cycle after the read
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we)
                mem[mem_addr[7:0]] = mem_wdata;
            else
                mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h cyc=%0d", n, act, exp, cyc);
        end
    endtask

    // Monitor: every memory access and every done pulse must match the queue head
    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            if (acc_q.size() == 0) begin
                chk("unexpected_mem_en", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                acc_t e;
                e = acc_q.pop_front();
                chk("mem_we", {31'h0, mem_we}, {31'h0, e.we});
                chk("mem_addr", {16'h0, mem_addr}, {16'h0, e.a});
                if (e.we) chk("mem_wdata", {24'h0, mem_wdata}, {24'h0, e.d});
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 32'h1, 32'h0);
            end else begin
                done_t d;
                d = done_q.pop_front();
                chk("done_cycle", d.cyc == cyc ? 32'h0 : cyc, d.cyc == cyc ? 32'h0 : d.cyc);
                chk("rdata", {16'h0, rdata}, {16'h0, d.rd});
                chk("misalign", {31'h0, misalign}, {31'h0, d.mis});
            end
        end else if (misalign === 1'b1) begin
            chk("misalign_without_done", 32'h1, 32'h0);
        end
    end

    task automatic do_req(input logic [1:0] o, input logic [15:0] a, input logic [15:0] w,
                          input int lat, input logic [15:0] exp_rd, input logic exp_mis);
        logic [15:0] hold;
        hold  = model_rd;
        start = 1'b1;
        op    = o;
        addr  = a;
        wdata = w;
        done_q.push_back('{cyc + lat, exp_rd, exp_mis});
        if (!exp_mis) begin
            case (o)
                OP_LB: acc_q.push_back('{1'b0, a, 8'h00});
                OP_LW: begin
                    acc_q.push_back('{1'b0, a, 8'h00});
                    acc_q.push_back('{1'b0, a | 16'h0001, 8'h00});
                end
                OP_SB: acc_q.push_back('{1'b1, a, w[7:0]});
                default: begin
                    acc_q.push_back('{1'b1, a, w[7:0]});
                    acc_q.push_back('{1'b1, a | 16'h0001, w[15:8]});
                end
            endcase
        end
        @(posedge clk); #1;
        // Scramble request inputs while busy; the latched request must win
        start = 1'b0;
        op    = ~o;
        addr  = 16'hFFFF;
        wdata = ~w;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk("busy_high", {31'h0, busy}, 32'h1);
            if (k < lat) chk("rdata_hold", {16'h0, rdata}, {16'h0, hold});
            @(posedge clk); #1;
        end
        model_rd = exp_rd;
        @(negedge clk);
        chk("busy_low_after", {31'h0, busy}, 32'h0);
        chk("rdata_after", {16'h0, rdata}, {16'h0, exp_rd});
        @(posedge clk); #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_misalign"}, {31'h0, misalign}, 32'h0);
        chk({tag, "_mem_en"}, {31'h0, mem_en}, 32'h0);
        chk({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
        chk({tag, "_mem_addr"}, {16'h0, mem_addr}, 32'h0);
        chk({tag, "_mem_wdata"}, {24'h0, mem_wdata}, 32'h0);
        chk({tag, "_rdata"}, {16'h0, rdata}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;
        mem[8'h20] = 8'h34;
        mem[8'h21] = 8'h12;

        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        do_req(OP_LB, 16'h0010, 16'h0000, 3, 16'h00A5, 1'b0);
        do_req(OP_LW, 16'h0020, 16'h0000, 4, 16'h1234, 1'b0);
        do_req(OP_SW, 16'h0040, 16'hBEEF, 3, 16'h1234, 1'b0);
        chk("mem40", {24'h0, mem[8'h40]}, 32'hEF);
        chk("mem41", {24'h0, mem[8'h41]}, 32'hBE);
        do_req(OP_SB, 16'h0041, 16'h0077, 2, 16'h1234, 1'b0);
        chk("mem41_sb", {24'h0, mem[8'h41]}, 32'h77);
        chk("mem40_kept", {24'h0, mem[8'h40]}, 32'hEF);
        do_req(OP_LW, 16'h0040, 16'h0000, 4, 16'h77EF, 1'b0);
        do_req(OP_LW, 16'h0031, 16'h0000, 1, 16'h77EF, 1'b1);
        do_req(OP_SW, 16'h0033, 16'hCAFE, 1, 16'h77EF, 1'b1);
        chk("mem33_untouched", {24'h0, mem[8'h33]}, 32'h00);

        // start held high: only IDLE cycles accept; busy-cycle SBs are dropped
        c0 = cyc;
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 0) begin
                op   = OP_LB;
                addr = 16'h0010;
                done_q.push_back('{c0 + i + 3, 16'h00A5, 1'b0});
                acc_q.push_back('{1'b0, 16'h0010, 8'h00});
            end else begin
                op    = OP_SB;
                addr  = 16'h0050;
                wdata = 16'h9999;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        model_rd = 16'h00A5;
        repeat (3) @(posedge clk);
        #1;
        chk("mem50_untouched", {24'h0, mem[8'h50]}, 32'h00);
        chk("cont_done_q_drained", done_q.size(), 32'h0);

        // Reset during RD_HI of an LW: both reads seen, then silence
        start = 1'b1;
        op    = OP_LW;
        addr  = 16'h0020;
        acc_q.push_back('{1'b0, 16'h0020, 8'h00});
        acc_q.push_back('{1'b0, 16'h0021, 8'h00});
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_rd = 16'h0000;
        chk_idle_outputs("midreset");
        repeat (4) @(posedge clk);
        #1;
        chk("midreset_acc_drained", acc_q.size(), 32'h0);
        do_req(OP_LB, 16'h0010, 16'h0000, 3, 16'h00A5, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("final_done_q_empty", done_q.size(), 32'h0);
        chk("final_acc_q_empty", acc_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
